fmap_stream_reader: RTL and testbench
=====================================

FMAP_STREAM_READER -- requirements
Module: fmap_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, pixel width.
REQ-002 SHALL have parameter IMG_WIDTH, default 64, unpadded columns.
REQ-003 SHALL have parameter IMG_HEIGHT, default 64, unpadded rows.
REQ-004 SHALL have parameter PAD, default 1, zero-border width (0 or 1).
REQ-005 SHALL have parameter ADDR_WIDTH, default 12, memory address width; it holds IMG_WIDTH*IMG_HEIGHT-1.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start  input  1  begin one frame; sampled only in IDLE.
REQ-009 SHALL have port busy  output  1  high in STREAM and DRAIN.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-011 SHALL have port mem_rd_en  output  1  synchronous-read strobe.
REQ-012 SHALL have port mem_rd_addr  output  ADDR_WIDTH  raster address, row*IMG_WIDTH+col.
REQ-013 SHALL have port mem_rd_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 SHALL have port out_pixel  output  DATA_WIDTH  streamed pixel.
REQ-015 SHALL have port out_valid  output  1  out_pixel valid.
REQ-016 SHALL have port out_ready  input  1  downstream accept; beat transfers when out_valid and out_ready are both high.

Function
REQ-017 SHALL emit a raster stream of (IMG_WIDTH+2*PAD) x (IMG_HEIGHT+2*PAD) pixels per frame: zero on border positions, mem[(r-PAD)*IMG_WIDTH+(c-PAD)] at interior positions.
REQ-018 SHALL use FSM states IDLE, STREAM, DRAIN: IDLE->STREAM on start; STREAM->DRAIN after the last position is issued; DRAIN->IDLE when the output FIFO is empty and no read is in flight, pulsing done in that transition cycle.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL issue one position per cycle in STREAM when FIFO occupancy plus in-flight count is below 2.
REQ-021 SHALL assert mem_rd_en only for interior positions; border positions SHALL generate zero without a memory read.
REQ-022 SHALL delay border-zero and memory-read positions through the same 1-cycle stage so that output order equals issue order.
REQ-023 SHALL buffer returned data in a 2-entry FIFO driving out_pixel/out_valid, so a beat is never dropped under backpressure.
REQ-024 SHALL hold out_pixel stable while out_valid is high and out_ready is low.
REQ-025 SHALL sustain 1 pixel/cycle when out_ready stays high; the first out_valid SHALL be 2 cycles after the cycle start is sampled.
REQ-026 SHALL generate addresses incrementally (no multiplier), with column and row wrap at padded width and height.
REQ-027 SHALL hold mem_rd_addr at its last value when mem_rd_en is low.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-frame, immediately return to IDLE and flush the FIFO and the in-flight stage.
REQ-029 SHALL reset busy, done, mem_rd_en, out_valid to 0 and mem_rd_addr, out_pixel, and the counters to 0.
REQ-030 SHALL require a new start after reset; no partial frame resumes.

Structure
REQ-031 SHALL place the FSM state encoding and the padded-dimension/frame-size constants in the shared dataflow package.
REQ-032 SHALL implement the 2-entry output FIFO as sub-module stream_fifo2 with valid/ready on both sides.

Verification
REQ-033 SHALL cover W=4, H=3, PAD=1, mem[i]=i+1, out_ready=1: 30 beats; beats 0-6 are 0, beat 7 is 1, beat 10 is 4; done pulses once; 12 mem_rd_en cycles.
REQ-034 SHALL cover PAD=0, same memory: 12 beats 1..12 on 12 consecutive cycles; first out_valid 2 cycles after start.
REQ-035 SHALL cover out_ready held low for 5 cycles mid-frame: out_pixel stable, at most 2 beats buffered, no beat lost or duplicated; sequence matches REQ-033.
REQ-036 SHALL cover random out_ready (50%) over a 64x64 frame: 4356 beats match the reference model; mem_rd_en count is 4096.
REQ-037 SHALL cover start pulsed during STREAM: frame unaffected, done pulses exactly once.
REQ-038 SHALL cover rst_n low at beat 10, then a new start: outputs 0 during reset; the new frame restarts from beat 0 with correct data.

Source files
------------

// File: rtl/fmap_stream_reader_pkg.sv
// Shared definitions for the feature-map stream reader dataflow.
// FSM encoding, default image geometry and padded-dimension helpers.
// Imported by the reader top and its output FIFO.
package fmap_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } fsm_state_e;

    localparam int DEF_IMG_WIDTH  = 64;
    localparam int DEF_IMG_HEIGHT = 64;
    localparam int DEF_PAD        = 1;

    // Output buffer depth; the issue credit check is sized against it.
    localparam int FIFO_DEPTH = 2;

    // Columns or rows including the zero border on both sides.
    function automatic int padded_dim(input int dim, input int pad);
        return dim + 2 * pad;
    endfunction

    // Beats emitted per frame.
    function automatic int frame_size(input int w, input int h, input int pad);
        return padded_dim(w, pad) * padded_dim(h, pad);
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready FIFO holding returned pixels for the output port.
// Latency: one clock from push to out_vld; out_dat comes straight from a slot register.
// Backpressure: in_rdy drops when both slots are full; head stays stable until popped.
module stream_fifo2
    import fmap_stream_reader_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic [1:0]       level
);

    logic [1:0][WIDTH-1:0] slot_q, slot_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            level_q, level_d;
    logic                  push, pop;

    assign in_rdy  = (level_q != 2'(FIFO_DEPTH));
    assign out_vld = (level_q != 2'd0);
    assign out_dat = slot_q[rd_ptr_q];
    assign level   = level_q;
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    // Next slot contents, pointers and occupancy from push/pop.
    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            slot_d[wr_ptr_q] = in_dat;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        level_d = level_q + 2'(push) - 2'(pop);
    end

    // Storage and pointer registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            level_q  <= 2'd0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/fmap_stream_reader.sv
// Streams a zero-padded feature map in raster order from a synchronous-read memory.
// Latency: first out_valid two clocks after start is sampled; then 1 pixel/clock.
// Backpressure: issue stalls on FIFO credit; the 2-entry FIFO holds beats while out_ready is low.
module fmap_stream_reader
    import fmap_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int PAD        = DEF_PAD,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] out_pixel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PW = padded_dim(IMG_WIDTH, PAD);
    localparam int PH = padded_dim(IMG_HEIGHT, PAD);
    localparam int CW = $clog2(PW + 1);
    localparam int RW = $clog2(PH + 1);

    fsm_state_e            state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;   // address of the next interior read
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;       // address of the last issued read
    logic                  infl_vld_q, infl_vld_d;
    logic                  infl_zero_q, infl_zero_d;

    logic                  interior;
    logic                  col_last, row_last;
    logic                  can_issue;
    logic                  pop;
    logic [2:0]            occ;
    logic [1:0]            fifo_level;
    logic                  fifo_in_rdy;
    logic [DATA_WIDTH-1:0] fifo_in_dat;

    // Interior test on the padded raster position; without a border every position is interior.
    if (PAD == 0) begin : g_nopad
        assign interior = 1'b1;
    end else begin : g_pad
        assign interior = (col_q >= CW'(PAD)) && (col_q < CW'(PAD + IMG_WIDTH)) &&
                          (row_q >= RW'(PAD)) && (row_q < RW'(PAD + IMG_HEIGHT));
    end

    assign col_last = (col_q == CW'(PW - 1));
    assign row_last = (row_q == RW'(PH - 1));

    // Credit counts occupancy after this cycle's pop so a full-rate stream never stalls.
    assign pop       = out_valid && out_ready;
    assign occ       = 3'(fifo_level) + 3'(infl_vld_q) - 3'(pop);
    assign can_issue = (state_q == ST_STREAM) && (occ < 3'(FIFO_DEPTH));

    assign busy        = (state_q != ST_IDLE);
    assign mem_rd_en   = can_issue && interior;
    assign mem_rd_addr = mem_rd_en ? rd_idx_q : addr_q;
    assign fifo_in_dat = infl_zero_q ? '0 : mem_rd_data;

    // Next-state, position walk and issue of one position per credited cycle.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        rd_idx_d    = rd_idx_q;
        addr_d      = addr_q;
        infl_vld_d  = 1'b0;
        infl_zero_d = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_STREAM;
                    col_d    = '0;
                    row_d    = '0;
                    rd_idx_d = '0;
                end
            end
            ST_STREAM: begin
                if (can_issue) begin
                    infl_vld_d  = 1'b1;
                    infl_zero_d = !interior;
                    if (interior) begin
                        addr_d   = rd_idx_q;
                        rd_idx_d = rd_idx_q + ADDR_WIDTH'(1);
                    end
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if ((fifo_level == 2'd0) && !infl_vld_q) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and the one-cycle in-flight stage; reset abandons any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            rd_idx_q    <= '0;
            addr_q      <= '0;
            infl_vld_q  <= 1'b0;
            infl_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rd_idx_q    <= rd_idx_d;
            addr_q      <= addr_d;
            infl_vld_q  <= infl_vld_d;
            infl_zero_q <= infl_zero_d;
        end
    end

    // Credit accounting guarantees room whenever the in-flight stage delivers.
    assert property (@(posedge clk) disable iff (!rst_n) infl_vld_q |-> fifo_in_rdy);

    stream_fifo2 #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (infl_vld_q),
        .in_rdy  (fifo_in_rdy),
        .in_dat  (fifo_in_dat),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (out_pixel),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed bench for fmap_stream_reader: three instances (4x3 pad 1, 4x3 pad 0, 64x64 pad 1).
// Each memory returns mem[i] = i + 1 one clock after the read strobe.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fmap_stream_reader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: 4x3, PAD=1
    logic        start_a = 1'b0, rdy_a = 1'b1;
    logic        busy_a, done_a, rd_en_a, vld_a;
    logic [3:0]  rd_addr_a;
    logic [15:0] rd_data_a = '0, pix_a;
    // Instance B: 4x3, PAD=0
    logic        start_b = 1'b0, rdy_b = 1'b1;
    logic        busy_b, done_b, rd_en_b, vld_b;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_b = '0, pix_b;
    // Instance C: 64x64, PAD=1
    logic        start_c = 1'b0, rdy_c = 1'b1;
    logic        busy_c, done_c, rd_en_c, vld_c;
    logic [11:0] rd_addr_c;
    logic [15:0] rd_data_c = '0, pix_c;

    fmap_stream_reader #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(3), .PAD(1), .ADDR_WIDTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_rd_en(rd_en_a), .mem_rd_addr(rd_addr_a), .mem_rd_data(rd_data_a),
        .out_pixel(pix_a), .out_valid(vld_a), .out_ready(rdy_a));

    fmap_stream_reader #(.DATA_WIDTH(16), .IMG_WIDTH(4), .IMG_HEIGHT(3), .PAD(0), .ADDR_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(rd_en_b), .mem_rd_addr(rd_addr_b), .mem_rd_data(rd_data_b),
        .out_pixel(pix_b), .out_valid(vld_b), .out_ready(rdy_b));

    fmap_stream_reader #(.DATA_WIDTH(16), .IMG_WIDTH(64), .IMG_HEIGHT(64), .PAD(1), .ADDR_WIDTH(12)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
        .mem_rd_en(rd_en_c), .mem_rd_addr(rd_addr_c), .mem_rd_data(rd_data_c),
        .out_pixel(pix_c), .out_valid(vld_c), .out_ready(rdy_c));

    // Synchronous-read memories holding mem[i] = i + 1.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= 16'(rd_addr_a) + 16'd1;
        if (rd_en_b) rd_data_b <= 16'(rd_addr_b) + 16'd1;
        if (rd_en_c) rd_data_c <= 16'(rd_addr_c) + 16'd1;
    end

    // Reference model: expected pixel for beat k of a padded frame.
    function automatic logic [15:0] exp_pix(input int k, input int w, input int h, input int pad);
        int pw, r, c;
        pw = w + 2 * pad;
        r  = k / pw;
        c  = k % pw;
        if (r < pad || r >= pad + h || c < pad || c >= pad + w) return 16'd0;
        return 16'((r - pad) * w + (c - pad) + 1);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done_a); end
        checks++; if (rd_en_a !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b expected 0", rd_en_a); end
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", vld_a); end
        checks++; if (rd_addr_a !== 4'd0) begin errors++; $display("FAIL reset_addr got %0d expected 0", rd_addr_a); end
        checks++; if (pix_a !== 16'd0) begin errors++; $display("FAIL reset_pixel got %0d expected 0", pix_a); end
        checks++; if (vld_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %b expected 0", vld_b); end
        checks++; if (busy_c !== 1'b0) begin errors++; $display("FAIL reset_busy_c got %b expected 0", busy_c); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_no_start got busy %b expected 0", busy_a); end
    endtask

    task automatic test_pad1();
        int beats = 0, dones = 0, reads = 0;
        logic [15:0] got[$];
        @(posedge clk); #1 start_a = 1'b1; rdy_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int e = 0; e < 100; e++) begin
            @(negedge clk);
            if (vld_a && rdy_a) begin
                checks++;
                if (pix_a !== exp_pix(beats, 4, 3, 1)) begin
                    errors++; $display("FAIL pad1_beat%0d got %0d expected %0d", beats, pix_a, exp_pix(beats, 4, 3, 1));
                end
                got.push_back(pix_a);
                beats++;
            end
            if (done_a) dones++;
            if (rd_en_a) reads++;
            @(posedge clk); #1;
        end
        checks++; if (beats != 30) begin errors++; $display("FAIL pad1_beats got %0d expected 30", beats); end
        checks++; if (dones != 1) begin errors++; $display("FAIL pad1_done got %0d pulses expected 1", dones); end
        checks++; if (reads != 12) begin errors++; $display("FAIL pad1_reads got %0d expected 12", reads); end
        if (got.size() > 10) begin
            checks++; if (got[7] !== 16'd1) begin errors++; $display("FAIL pad1_beat7 got %0d expected 1", got[7]); end
            checks++; if (got[10] !== 16'd4) begin errors++; $display("FAIL pad1_beat10 got %0d expected 4", got[10]); end
        end
    endtask

    task automatic test_pad0();
        int beats = 0, dones = 0, first = -1;
        @(posedge clk); #1 start_b = 1'b1; rdy_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            if (vld_b && first < 0) first = e;
            if (vld_b && rdy_b) begin
                checks++;
                if (pix_b !== 16'(beats + 1) || e != 2 + beats) begin
                    errors++; $display("FAIL pad0_beat%0d got %0d at edge %0d expected %0d at edge %0d", beats, pix_b, e, beats + 1, 2 + beats);
                end
                beats++;
            end
            if (done_b) dones++;
            @(posedge clk); #1;
        end
        checks++; if (first != 2) begin errors++; $display("FAIL pad0_latency got %0d expected 2", first); end
        checks++; if (beats != 12) begin errors++; $display("FAIL pad0_beats got %0d expected 12", beats); end
        checks++; if (dones != 1) begin errors++; $display("FAIL pad0_done got %0d pulses expected 1", dones); end
    endtask

    task automatic test_backpressure();
        int beats = 0, dones = 0, stall_vld = 0, max_level = 0;
        logic held_vld = 1'b0;
        logic [15:0] held_pix = '0;
        @(posedge clk); #1 start_a = 1'b1; rdy_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int e = 0; e < 100; e++) begin
            rdy_a = !(e >= 12 && e < 17);
            @(negedge clk);
            if (int'(dut_a.fifo_level) > max_level) max_level = int'(dut_a.fifo_level);
            if (vld_a && !rdy_a) begin
                stall_vld++;
                if (held_vld) begin
                    checks++;
                    if (pix_a !== held_pix) begin errors++; $display("FAIL bp_stable got %0d expected %0d", pix_a, held_pix); end
                end
                held_vld = 1'b1;
                held_pix = pix_a;
            end else begin
                held_vld = 1'b0;
            end
            if (vld_a && rdy_a) begin
                checks++;
                if (pix_a !== exp_pix(beats, 4, 3, 1)) begin
                    errors++; $display("FAIL bp_beat%0d got %0d expected %0d", beats, pix_a, exp_pix(beats, 4, 3, 1));
                end
                beats++;
            end
            if (done_a) dones++;
            @(posedge clk); #1;
        end
        rdy_a = 1'b1;
        checks++; if (stall_vld != 5) begin errors++; $display("FAIL bp_stall_cycles got %0d expected 5", stall_vld); end
        checks++; if (max_level != 2) begin errors++; $display("FAIL bp_buffered got %0d expected 2", max_level); end
        checks++; if (beats != 30) begin errors++; $display("FAIL bp_beats got %0d expected 30", beats); end
        checks++; if (dones != 1) begin errors++; $display("FAIL bp_done got %0d pulses expected 1", dones); end
    endtask

    task automatic test_start_in_stream();
        int beats = 0, dones = 0, reads = 0;
        @(posedge clk); #1 start_a = 1'b1; rdy_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int e = 0; e < 100; e++) begin
            start_a = (e == 8);
            @(negedge clk);
            if (vld_a && rdy_a) begin
                checks++;
                if (pix_a !== exp_pix(beats, 4, 3, 1)) begin
                    errors++; $display("FAIL restart_beat%0d got %0d expected %0d", beats, pix_a, exp_pix(beats, 4, 3, 1));
                end
                beats++;
            end
            if (done_a) dones++;
            if (rd_en_a) reads++;
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        checks++; if (beats != 30) begin errors++; $display("FAIL restart_beats got %0d expected 30", beats); end
        checks++; if (dones != 1) begin errors++; $display("FAIL restart_done got %0d pulses expected 1", dones); end
        checks++; if (reads != 12) begin errors++; $display("FAIL restart_reads got %0d expected 12", reads); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL restart_idle got busy %b expected 0", busy_a); end
    endtask

    task automatic test_reset_midframe();
        int beats = 0, dones = 0, reads = 0;
        logic hit = 1'b0;
        @(posedge clk); #1 start_a = 1'b1; rdy_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int e = 0; e < 60 && !hit; e++) begin
            @(negedge clk);
            if (vld_a && beats == 10) begin
                hit = 1'b1;
            end else begin
                if (vld_a) beats++;
                @(posedge clk); #1;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_reach_beat10 got %0d beats expected 10", beats); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy_a); end
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL rst_valid got %b expected 0", vld_a); end
        checks++; if (rd_en_a !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b expected 0", rd_en_a); end
        checks++; if (rd_addr_a !== 4'd0) begin errors++; $display("FAIL rst_addr got %0d expected 0", rd_addr_a); end
        checks++; if (pix_a !== 16'd0) begin errors++; $display("FAIL rst_pixel got %0d expected 0", pix_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rst_done got %b expected 0", done_a); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int e = 0; e < 5; e++) begin
            @(negedge clk);
            checks++; if (busy_a !== 1'b0 || vld_a !== 1'b0) begin
                errors++; $display("FAIL rst_no_resume got busy %b valid %b expected 0 0", busy_a, vld_a);
            end
            @(posedge clk); #1;
        end
        beats = 0;
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int e = 0; e < 100; e++) begin
            @(negedge clk);
            if (vld_a && rdy_a) begin
                checks++;
                if (pix_a !== exp_pix(beats, 4, 3, 1)) begin
                    errors++; $display("FAIL rst_new_beat%0d got %0d expected %0d", beats, pix_a, exp_pix(beats, 4, 3, 1));
                end
                beats++;
            end
            if (done_a) dones++;
            if (rd_en_a) reads++;
            @(posedge clk); #1;
        end
        checks++; if (beats != 30) begin errors++; $display("FAIL rst_new_beats got %0d expected 30", beats); end
        checks++; if (dones != 1) begin errors++; $display("FAIL rst_new_done got %0d pulses expected 1", dones); end
        checks++; if (reads != 12) begin errors++; $display("FAIL rst_new_reads got %0d expected 12", reads); end
    endtask

    task automatic test_random_64();
        int beats = 0, dones = 0, reads = 0;
        @(posedge clk); #1 start_c = 1'b1; rdy_c = 1'b1;
        @(posedge clk); #1 start_c = 1'b0;
        for (int e = 0; e < 20000 && dones == 0; e++) begin
            rdy_c = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (vld_c && rdy_c) begin
                checks++;
                if (pix_c !== exp_pix(beats, 64, 64, 1)) begin
                    errors++; $display("FAIL rand_beat%0d got %0d expected %0d", beats, pix_c, exp_pix(beats, 64, 64, 1));
                end
                beats++;
            end
            if (done_c) dones++;
            if (rd_en_c) reads++;
            @(posedge clk); #1;
        end
        rdy_c = 1'b1;
        checks++; if (beats != 4356) begin errors++; $display("FAIL rand_beats got %0d expected 4356", beats); end
        checks++; if (reads != 4096) begin errors++; $display("FAIL rand_reads got %0d expected 4096", reads); end
        checks++; if (dones != 1) begin errors++; $display("FAIL rand_done got %0d pulses expected 1", dones); end
    endtask

    initial begin
        test_reset();
        test_pad1();
        test_pad0();
        test_backpressure();
        test_start_in_stream();
        test_reset_midframe();
        test_random_64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
